// File: rtl/imem_program_loader_pkg.sv
// rtl/imem_program_loader_pkg.sv - shared opcode constants, instruction field layout, loader states
//
// Purpose: opcode values and 8-bit instruction field positions shared by
// main control (decoder) and the program loader (encoder), plus loader FSM states.
package imem_program_loader_pkg;

  localparam logic [1:0] OP_LI  = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ILL = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  localparam int INSTR_W = 8;

  // Field bit positions inside the encoded instruction word
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 6;
  localparam int RD_MSB = 5;
  localparam int RD_LSB = 4;
  localparam int RS_MSB = 3;
  localparam int RS_LSB = 2;

  // Immediate widths that each opcode can carry
  localparam int LI_IMM_W  = 4;
  localparam int SLL_SH_W  = 2;
  localparam int JMP_TGT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/imem_program_loader_instr_encoder.sv
// rtl/imem_program_loader_instr_encoder.sv - combinational field-to-instruction encoder
//
// Purpose: turns op/rd/rs/imm fields into the 8-bit instruction word and flags
// whether the field combination is encodable.
// Ports:
//   i_op, i_rd, i_rs  in   2  instruction fields
//   i_imm             in   6  immediate / shift amount / jump target
//   o_wdata           out  8  encoded instruction
//   o_legal           out  1  fields are encodable without losing bits
module imem_program_loader_instr_encoder
  import imem_program_loader_pkg::*;
(
  input  logic [1:0]         i_op,
  input  logic [1:0]         i_rd,
  input  logic [1:0]         i_rs,
  input  logic [5:0]         i_imm,
  output logic [INSTR_W-1:0] o_wdata,
  output logic               o_legal
);

  always_comb begin
    o_wdata                 = '0;
    o_legal                 = 1'b0;
    o_wdata[OP_MSB:OP_LSB]  = i_op;
    case (i_op)
      OP_LI: begin
        o_wdata[RD_MSB:RD_LSB]   = i_rd;
        o_wdata[LI_IMM_W-1:0]    = i_imm[LI_IMM_W-1:0];
        // Upper immediate bits would be silently dropped, so reject them
        o_legal                  = (i_imm[5:LI_IMM_W] == '0);
      end
      OP_SLL: begin
        o_wdata[RD_MSB:RD_LSB]   = i_rd;
        o_wdata[RS_MSB:RS_LSB]   = i_rs;
        o_wdata[SLL_SH_W-1:0]    = i_imm[SLL_SH_W-1:0];
        o_legal                  = (i_imm[5:SLL_SH_W] == '0);
      end
      OP_JMP: begin
        o_wdata[JMP_TGT_W-1:0]   = i_imm[JMP_TGT_W-1:0];
        o_legal                  = 1'b1;
      end
      default: begin
        o_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - streams field-level instructions into instruction memory
//
// Purpose: accepts op/rd/rs/imm beats, validates and encodes them, and writes
// them to consecutive imem addresses from 0 after a start pulse.
// Ports:
//   i_clk, i_rst (sync, active-low), i_start (begin load at address 0)
//   i_in_valid/o_in_ready, i_in_op/rd/rs/imm, i_in_last : instruction stream
//   o_imem_we/o_imem_addr/o_imem_wdata                 : memory write port
//   o_busy, o_done, o_err, o_count                      : load status
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter  int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [1:0]         i_in_op,
  input  logic [1:0]         i_in_rd,
  input  logic [1:0]         i_in_rs,
  input  logic [5:0]         i_in_imm,
  input  logic               i_in_last,
  output logic               o_imem_we,
  output logic [ADDR_W-1:0]  o_imem_addr,
  output logic [INSTR_W-1:0] o_imem_wdata,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [ADDR_W:0]    o_count
);

  localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W+1)'(DEPTH);

  state_t               r_state;
  state_t               w_next;
  logic [ADDR_W:0]      r_ptr;
  logic                 r_we;
  logic [ADDR_W-1:0]    r_addr;
  logic [INSTR_W-1:0]   r_wdata;

  logic [INSTR_W-1:0]   w_wdata;
  logic                 w_legal;
  logic                 w_accept;
  logic                 w_bad;
  logic                 w_good_wr;
  logic                 w_restart;

  imem_program_loader_instr_encoder u_encoder (
    .i_op    (i_in_op),
    .i_rd    (i_in_rd),
    .i_rs    (i_in_rs),
    .i_imm   (i_in_imm),
    .o_wdata (w_wdata),
    .o_legal (w_legal)
  );

  assign w_accept  = i_in_valid && o_in_ready;
  // Once DEPTH words are written any further beat has nowhere to go
  assign w_bad     = !w_legal || (r_ptr == PTR_FULL);
  assign w_good_wr = w_accept && !w_bad;
  // start is only honoured outside LOAD
  assign w_restart = i_start && (r_state != ST_LOAD);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_next = ST_LOAD;
      ST_LOAD: begin
        if (w_accept && w_bad)          w_next = ST_ERR;
        else if (w_accept && i_in_last) w_next = ST_DONE;
      end
      ST_DONE: if (i_start) w_next = ST_LOAD;
      ST_ERR:  if (i_start) w_next = ST_LOAD;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready = (r_state == ST_LOAD);
    o_busy     = (r_state == ST_LOAD);
    o_done     = (r_state == ST_DONE);
    o_err      = (r_state == ST_ERR);
  end

  // Write port is registered: one cycle of latency from accept to write,
  // and address/data hold between pulses.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_ptr   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_good_wr;
      if (w_restart) begin
        r_ptr <= '0;
      end else if (w_good_wr) begin
        r_addr  <= r_ptr[ADDR_W-1:0];
        r_wdata <= w_wdata;
        r_ptr   <= r_ptr + (ADDR_W+1)'(1);
      end
    end
  end

  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_count      = r_ptr;

endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - self-checking bench for imem_program_loader
module tb_imem_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [1:0] in_op = 2'b00;
  logic [1:0] in_rd = 2'b00;
  logic [1:0] in_rs = 2'b00;
  logic [5:0] in_imm = 6'd0;

  logic       rdy_a, we_a, busy_a, done_a, err_a;
  logic [5:0] addr_a;
  logic [7:0] wd_a;
  logic [6:0] cnt_a;

  logic       rdy_b, we_b, busy_b, done_b, err_b;
  logic [1:0] addr_b;
  logic [7:0] wd_b;
  logic [2:0] cnt_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit tgt4 = 1'b0;

  int qa_a[$];
  int qd_a[$];
  int qc_a[$];
  int qa_b[$];
  int qd_b[$];

  imem_program_loader #(.DEPTH(64)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid),
    .o_in_ready(rdy_a), .i_in_op(in_op), .i_in_rd(in_rd), .i_in_rs(in_rs),
    .i_in_imm(in_imm), .i_in_last(in_last), .o_imem_we(we_a),
    .o_imem_addr(addr_a), .o_imem_wdata(wd_a), .o_busy(busy_a),
    .o_done(done_a), .o_err(err_a), .o_count(cnt_a)
  );

  imem_program_loader #(.DEPTH(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid),
    .o_in_ready(rdy_b), .i_in_op(in_op), .i_in_rd(in_rd), .i_in_rs(in_rs),
    .i_in_imm(in_imm), .i_in_last(in_last), .o_imem_we(we_b),
    .o_imem_addr(addr_b), .o_imem_wdata(wd_b), .o_busy(busy_b),
    .o_done(done_b), .o_err(err_b), .o_count(cnt_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we_a) begin
      qa_a.push_back(int'(addr_a));
      qd_a.push_back(int'(wd_a));
      qc_a.push_back(cyc);
    end
    if (we_b) begin
      qa_b.push_back(int'(addr_b));
      qd_b.push_back(int'(wd_b));
    end
  end

  // Reference encoding from the instruction format: op selects a 64-word
  // region of the code space, fields are packed by place value.
  function automatic bit model_enc(input int op, input int rd, input int rs,
                                   input int imm, output int word);
    word = 0;
    case (op)
      0: begin word = rd * 16 + imm;               return imm < 16; end
      1: begin word = 64 + rd * 16 + rs * 4 + imm; return imm < 4;  end
      3: begin word = 192 + imm;                   return 1'b1;     end
      default: return 1'b0;
    endcase
  endfunction

  task automatic clear_q();
    qa_a.delete(); qd_a.delete(); qc_a.delete(); qa_b.delete(); qd_b.delete();
  endtask

  task automatic start_load();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs,
                           input logic [5:0] imm, input logic last, output bit ok);
    in_op = op; in_rd = rd; in_rs = rs; in_imm = imm; in_last = last; in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (tgt4 ? rdy_b : rdy_a) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      in_valid = 1'b0;
      checks++; failures++;
      $display("FAIL ready_timeout got=in_ready_low exp=in_ready_high");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rdy_a, we_a, busy_a, done_a, err_a} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000", {rdy_a, we_a, busy_a, done_a, err_a});
    end
    checks++;
    if (addr_a !== 6'd0 || wd_a !== 8'd0 || cnt_a !== 7'd0) begin
      failures++;
      $display("FAIL reset_data got=addr%0d/data%0h/cnt%0d exp=0/0/0", addr_a, wd_a, cnt_a);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_li();
    bit ok;
    clear_q();
    start_load();
    send_beat(2'b00, 2'd2, 2'd0, 6'd5, 1'b1, ok);
    checks++;
    if (done_a !== 1'b1 || err_a !== 1'b0 || rdy_a !== 1'b0) begin
      failures++;
      $display("FAIL li_status got=done%b err%b rdy%b exp=done1 err0 rdy0", done_a, err_a, rdy_a);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (qa_a.size() != 1 || qa_a[0] != 0 || qd_a[0] != 'h25) begin
      failures++;
      $display("FAIL li_write got=n%0d exp=n1 addr0 data25", qa_a.size());
    end
    checks++;
    if (cnt_a !== 7'd1) begin
      failures++;
      $display("FAIL li_count got=%0d exp=1", cnt_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int exp_d[3] = '{'h5E, 'hEA, 'h3F};
    clear_q();
    start_load();
    send_beat(2'b01, 2'd1, 2'd3, 6'd2,  1'b0, ok);
    send_beat(2'b11, 2'd0, 2'd0, 6'h2A, 1'b0, ok);
    send_beat(2'b00, 2'd3, 2'd0, 6'hF,  1'b1, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (qa_a.size() != 3) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=3", qa_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (qa_a[i] != i || qd_a[i] != exp_d[i]) begin
          failures++;
          $display("FAIL b2b_write%0d got=a%0d/d%0h exp=a%0d/d%0h", i, qa_a[i], qd_a[i], i, exp_d[i]);
        end
      end
      checks++;
      if (qc_a[1] != qc_a[0] + 1 || qc_a[2] != qc_a[1] + 1) begin
        failures++;
        $display("FAIL b2b_spacing got=%0d,%0d,%0d exp=consecutive", qc_a[0], qc_a[1], qc_a[2]);
      end
    end
    checks++;
    if (done_a !== 1'b1 || cnt_a !== 7'd3) begin
      failures++;
      $display("FAIL b2b_status got=done%b cnt%0d exp=done1 cnt3", done_a, cnt_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal_op();
    bit ok;
    clear_q();
    start_load();
    send_beat(2'b00, 2'd0, 2'd0, 6'd1, 1'b0, ok);
    send_beat(2'b10, 2'd1, 2'd1, 6'd1, 1'b0, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (qa_a.size() != 1 || qa_a[0] != 0 || qd_a[0] != 'h01) begin
      failures++;
      $display("FAIL illop_write got=n%0d exp=n1 addr0 data01", qa_a.size());
    end
    checks++;
    if (err_a !== 1'b1 || done_a !== 1'b0 || rdy_a !== 1'b0 || cnt_a !== 7'd1) begin
      failures++;
      $display("FAIL illop_status got=err%b done%b rdy%b cnt%0d exp=err1 done0 rdy0 cnt1",
               err_a, done_a, rdy_a, cnt_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    bit ok;
    tgt4 = 1'b1;
    clear_q();
    start_load();
    for (int i = 0; i < 5; i++)
      send_beat(2'b00, 2'(i), 2'd0, 6'(i), 1'(i == 4), ok);
    repeat (2) @(negedge clk);
    checks++;
    if (qa_b.size() != 4 || qa_b[3] != 3 || qd_b[3] != 'h33) begin
      failures++;
      $display("FAIL ovf_writes got=n%0d exp=n4 last addr3 data33", qa_b.size());
    end
    checks++;
    if (err_b !== 1'b1 || done_b !== 1'b0 || cnt_b !== 3'd4) begin
      failures++;
      $display("FAIL ovf_status got=err%b done%b cnt%0d exp=err1 done0 cnt4", err_b, done_b, cnt_b);
    end
    @(posedge clk); #1;
    clear_q();
    start_load();
    for (int i = 0; i < 4; i++)
      send_beat(2'b11, 2'd0, 2'd0, 6'(i + 8), 1'(i == 3), ok);
    repeat (2) @(negedge clk);
    checks++;
    if (qa_b.size() != 4 || qa_b[3] != 3 || qd_b[3] != 'hCB) begin
      failures++;
      $display("FAIL full_writes got=n%0d exp=n4 last addr3 dataCB", qa_b.size());
    end
    checks++;
    if (done_b !== 1'b1 || err_b !== 1'b0 || cnt_b !== 3'd4) begin
      failures++;
      $display("FAIL full_status got=done%b err%b cnt%0d exp=done1 err0 cnt4", done_b, err_b, cnt_b);
    end
    tgt4 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    bit ok;
    clear_q();
    start_load();
    send_beat(2'b00, 2'd1, 2'd0, 6'd3, 1'b0, ok);
    send_beat(2'b01, 2'd2, 2'd1, 6'd1, 1'b0, ok);
    in_op = 2'b11; in_imm = 6'd9; in_last = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (we_a !== 1'b0) begin
        failures++;
        $display("FAIL midrst_we cycle%0d got=%b exp=0", k, we_a);
      end
    end
    checks++;
    if ({rdy_a, busy_a, done_a, err_a} !== 4'b0 || addr_a !== 6'd0 || wd_a !== 8'd0 || cnt_a !== 7'd0) begin
      failures++;
      $display("FAIL midrst_outputs got=flags%b addr%0d data%0h cnt%0d exp=all0",
               {rdy_a, busy_a, done_a, err_a}, addr_a, wd_a, cnt_a);
    end
    checks++;
    if (qa_a.size() != 2) begin
      failures++;
      $display("FAIL midrst_writes got=%0d exp=2", qa_a.size());
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    clear_q();
    start_load();
    send_beat(2'b00, 2'd0, 2'd0, 6'd7, 1'b1, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (qa_a.size() != 1 || qa_a[0] != 0 || qd_a[0] != 'h07 || done_a !== 1'b1) begin
      failures++;
      $display("FAIL midrst_restart got=n%0d done%b exp=n1 addr0 data07 done1", qa_a.size(), done_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_idle_and_busy_start();
    bit ok;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_q();
    in_op = 2'b00; in_rd = 2'd1; in_imm = 6'd1; in_last = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (rdy_a !== 1'b0 || we_a !== 1'b0) begin
        failures++;
        $display("FAIL idle_valid cycle%0d got=rdy%b we%b exp=rdy0 we0", k, rdy_a, we_a);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    start_load();
    send_beat(2'b00, 2'd1, 2'd0, 6'd2, 1'b0, ok);
    start_load();
    send_beat(2'b11, 2'd0, 2'd0, 6'h3F, 1'b1, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (qa_a.size() != 2 || qa_a[0] != 0 || qd_a[0] != 'h12 || qa_a[1] != 1 || qd_a[1] != 'hFF) begin
      failures++;
      $display("FAIL busy_start_writes got=n%0d exp=n2 a0/12 a1/FF", qa_a.size());
    end
    checks++;
    if (cnt_a !== 7'd2 || done_a !== 1'b1) begin
      failures++;
      $display("FAIL busy_start_status got=cnt%0d done%b exp=cnt2 done1", cnt_a, done_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit ok;
    int exp_d[$];
    bit exp_err;
    int len, op, rd, rs, imm, word, gap, bad;
    for (int p = 0; p < 25; p++) begin
      clear_q();
      exp_d.delete();
      exp_err = 1'b0;
      len = int'($urandom_range(1, 10));
      start_load();
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 9))
          0:       op = 2;
          1, 2, 3: op = 0;
          4, 5, 6: op = 1;
          default: op = 3;
        endcase
        rd = int'($urandom_range(0, 3));
        rs = int'($urandom_range(0, 3));
        bad = ($urandom_range(0, 11) == 0) ? 1 : 0;
        if (op == 0)      imm = bad ? int'($urandom_range(16, 63)) : int'($urandom_range(0, 15));
        else if (op == 1) imm = bad ? int'($urandom_range(4, 63))  : int'($urandom_range(0, 3));
        else              imm = int'($urandom_range(0, 63));
        send_beat(2'(op), 2'(rd), 2'(rs), 6'(imm), 1'(i == len - 1), ok);
        if (model_enc(op, rd, rs, imm, word)) begin
          exp_d.push_back(word);
        end else begin
          exp_err = 1'b1;
          break;
        end
        gap = int'($urandom_range(0, 2));
        repeat (gap) begin @(posedge clk); #1; end
      end
      repeat (2) @(negedge clk);
      checks++;
      bad = (qa_a.size() != exp_d.size()) ? 1 : 0;
      if (bad == 0)
        foreach (exp_d[i]) if (qa_a[i] != i || qd_a[i] != exp_d[i]) bad = 1;
      if (bad != 0) begin
        failures++;
        $display("FAIL rand%0d_writes got=n%0d exp=n%0d", p, qa_a.size(), exp_d.size());
      end
      checks++;
      if (err_a !== exp_err || done_a !== !exp_err || int'(cnt_a) != exp_d.size()) begin
        failures++;
        $display("FAIL rand%0d_status got=err%b done%b cnt%0d exp=err%b done%b cnt%0d",
                 p, err_a, done_a, cnt_a, exp_err, !exp_err, exp_d.size());
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_li();
    test_back_to_back();
    test_illegal_op();
    test_overflow();
    test_mid_reset();
    test_idle_and_busy_start();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
